sd_cmd_phy: RTL and testbench

SD_CMD_PHY -- requirements
Module: sd_cmd_phy

---
 rtl/sd_cmd_phy.sv | 197 +++++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: shifts out a 48-bit command frame with CRC7, then waits for and captures a 48/136-bit response.
// Define SDHOST_RESP_CRC_EN to build the response CRC7 checker; when undefined crc_err is tied low.
module sd_cmd_phy #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sd_clk_en,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  input  logic [1:0]   resp_type,
  input  logic         index_check_en,
  input  logic         crc_check_en,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_oe,
  output logic         busy,
  output logic [127:0] response,
  output logic         resp_valid,
  input  logic         resp_ack,
  output logic         cmd_done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic         index_err,
  output logic         end_bit_err
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [47:0]   tx_shift;
  logic [7:0]    bit_cnt;
  logic [WW-1:0] wait_cnt;
  logic [126:0]  rx_shift;
  logic [127:0]  rx_next;
  logic [5:0]    idx_q;
  logic [1:0]    rt_q;
  logic          idx_chk_q;
  logic          long_rsp, rx_last, wait_expire;

  // Direct-form CRC7 (x^7 + x^3 + 1), one bit at a time, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  assign long_rsp    = (rt_q == 2'b01);
  assign rx_last     = (bit_cnt == (long_rsp ? 8'd135 : 8'd47));
  assign wait_expire = (wait_cnt == WW'(TIMEOUT_CYCLES - 1));
  // The last 128 received bits, including the one being sampled now.
  assign rx_next     = {rx_shift, cmd_pin_in};

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_TX;
      S_TX:   if (sd_clk_en && bit_cnt == 8'd47) state_nxt = (rt_q == 2'b00) ? S_DONE : S_WAIT;
      S_WAIT: if (sd_clk_en) begin
        if (!cmd_pin_in)      state_nxt = S_RX;
        else if (wait_expire) state_nxt = S_DONE;
      end
      S_RX:   if (sd_clk_en && rx_last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_oe      = 1'b0;
    cmd_pin_out = 1'b1;
    busy        = 1'b0;
    cmd_done    = 1'b0;
    case (state)
      S_TX: begin
        cmd_oe      = 1'b1;
        cmd_pin_out = tx_shift[47];
        busy        = 1'b1;
      end
      S_WAIT, S_RX: busy = 1'b1;
      S_DONE:       cmd_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_shift    <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      rx_shift    <= '0;
      idx_q       <= '0;
      rt_q        <= '0;
      idx_chk_q   <= 1'b0;
      response    <= '0;
      resp_valid  <= 1'b0;
      timeout_err <= 1'b0;
      index_err   <= 1'b0;
      end_bit_err <= 1'b0;
    end else begin
      // A completing response below overrides this clear, so data arriving with an ack stays valid.
      if (resp_ack) resp_valid <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          idx_q       <= cmd_index;
          rt_q        <= resp_type;
          idx_chk_q   <= index_check_en;
          tx_shift    <= {2'b01, cmd_index, cmd_argument,
                          crc7_40({2'b01, cmd_index, cmd_argument}), 1'b1};
          bit_cnt     <= '0;
          timeout_err <= 1'b0;
          index_err   <= 1'b0;
          end_bit_err <= 1'b0;
        end
        S_TX: if (sd_clk_en) begin
          tx_shift <= {tx_shift[46:0], 1'b1};
          bit_cnt  <= bit_cnt + 8'd1;
          wait_cnt <= '0;
        end
        S_WAIT: if (sd_clk_en) begin
          if (!cmd_pin_in) begin
            rx_shift <= '0;
            bit_cnt  <= 8'd1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
            if (wait_expire) timeout_err <= 1'b1;
          end
        end
        S_RX: if (sd_clk_en) begin
          rx_shift <= rx_next[126:0];
          bit_cnt  <= bit_cnt + 8'd1;
          if (rx_last) begin
            resp_valid  <= 1'b1;
            end_bit_err <= ~rx_next[0];
            if (long_rsp) begin
              response  <= {8'h00, rx_next[127:8]};
              index_err <= 1'b0;
            end else begin
              response  <= {96'h0, rx_next[39:8]};
              index_err <= idx_chk_q && (rx_next[45:40] != idx_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SDHOST_RESP_CRC_EN
  logic [6:0] rx_crc;
  logic       crc_chk_q;
  logic       crc_bit_in;

  // 48-bit responses cover bits 0..39 (start bit onward); 136-bit cover bits 8..127 (the CID/CSD body).
  assign crc_bit_in = long_rsp ? (bit_cnt >= 8'd8 && bit_cnt <= 8'd127) : (bit_cnt <= 8'd39);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_crc    <= '0;
      crc_chk_q <= 1'b0;
      crc_err   <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        crc_chk_q <= crc_check_en;
        crc_err   <= 1'b0;
      end
      if (state == S_WAIT && sd_clk_en && !cmd_pin_in) rx_crc <= '0;
      if (state == S_RX && sd_clk_en) begin
        if (crc_bit_in) rx_crc <= crc7_step(rx_crc, cmd_pin_in);
        if (rx_last)    crc_err <= crc_chk_q && (rx_crc != rx_next[7:1]);
      end
    end
  end
`else
  logic unused_crc;
  assign crc_err    = 1'b0;
  assign unused_crc = crc_check_en ^ (^rx_next[7:1]);
`endif

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Scoreboard bench for sd_cmd_phy: stimulus pushes expected frames/completions, monitors pop and compare.
`timescale 1ns/1ps
module tb_sd_cmd_phy;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         sd_clk_en = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_argument = '0;
  logic [1:0]   resp_type = '0;
  logic         index_check_en = 1'b0;
  logic         crc_check_en = 1'b0;
  logic         cmd_pin_in = 1'b1;
  logic         resp_ack = 1'b0;
  logic         cmd_pin_out, cmd_oe, busy, resp_valid, cmd_done;
  logic [127:0] response;
  logic         timeout_err, crc_err, index_err, end_bit_err;

  sd_cmd_phy #(.TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset), .sd_clk_en(sd_clk_en), .start(start),
    .cmd_index(cmd_index), .cmd_argument(cmd_argument), .resp_type(resp_type),
    .index_check_en(index_check_en), .crc_check_en(crc_check_en),
    .cmd_pin_in(cmd_pin_in), .cmd_pin_out(cmd_pin_out), .cmd_oe(cmd_oe),
    .busy(busy), .response(response), .resp_valid(resp_valid), .resp_ack(resp_ack),
    .cmd_done(cmd_done), .timeout_err(timeout_err), .crc_err(crc_err),
    .index_err(index_err), .end_bit_err(end_bit_err)
  );

`ifdef SDHOST_RESP_CRC_EN
  localparam logic EXP_CRC_BAD = 1'b1;
`else
  localparam logic EXP_CRC_BAD = 1'b0;
`endif

  typedef struct {
    logic         rv;
    logic [127:0] resp;
    logic         to, ce, ie, ee;
    int           clks;
    int           strobes;
  } exp_t;

  exp_t        done_q[$];
  logic [47:0] tx_q[$];
  int          checks = 0;
  int          passed = 0;
  int          done_cnt = 0;
  int          tx_bits = 0;
  int          clks_since = 0;
  int          strobes_since = 0;
  logic [47:0] cap = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Augmented long division by x^7+x^3+1 over the low n bits of d.
  function automatic logic [6:0] crc_model(input logic [127:0] d, input int n);
    logic [7:0] r;
    logic       b;
    r = '0;
    for (int i = n - 1; i >= -7; i--) begin
      b = 1'b0;
      if (i >= 0) b = d[i];
      r = {r[6:0], b};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame48(input logic [39:0] head);
    return {head, crc_model({88'h0, head}, 40), 1'b1};
  endfunction

  function automatic exp_t mk_exp(input logic rv, input logic [127:0] resp, input logic to,
                                  input logic ce, input logic ie, input logic ee,
                                  input int clks, input int strobes);
    exp_t e;
    e.rv = rv; e.resp = resp; e.to = to; e.ce = ce; e.ie = ie; e.ee = ee;
    e.clks = clks; e.strobes = strobes;
    return e;
  endfunction

  initial forever #5 clock = ~clock;

  // One strobe every fourth clock.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clock);
      #1;
      div = (div + 1) % 4;
      sd_clk_en = (div == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: captures TX frames and scores completions, both on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clock);
    clks_since++;
    if (sd_clk_en && !cmd_oe) strobes_since++;
    if (!cmd_oe && tx_bits != 0) tx_bits = 0;
    if (cmd_oe && sd_clk_en) begin
      cap = {cap[46:0], cmd_pin_out};
      tx_bits++;
      if (tx_bits == 48) begin
        tx_bits = 0;
        clks_since = 0;
        strobes_since = 0;
        if (tx_q.size() == 0) check("tx_unexpected", {127'h0, cmd_oe}, 128'h0);
        else check("tx_frame", {80'h0, cap}, {80'h0, tx_q.pop_front()});
      end
    end
    if (cmd_done) begin
      done_cnt++;
      if (done_q.size() == 0) check("done_unexpected", {127'h0, cmd_done}, 128'h0);
      else begin
        e = done_q.pop_front();
        check("busy_at_done", {127'h0, busy}, 128'h0);
        check("line_idle_at_done", {126'h0, cmd_oe, cmd_pin_out}, 128'h1);
        check("timeout_err", {127'h0, timeout_err}, {127'h0, e.to});
        check("crc_err", {127'h0, crc_err}, {127'h0, e.ce});
        check("index_err", {127'h0, index_err}, {127'h0, e.ie});
        check("end_bit_err", {127'h0, end_bit_err}, {127'h0, e.ee});
        check("resp_valid", {127'h0, resp_valid}, {127'h0, e.rv});
        if (e.rv) check("response", response, e.resp);
        if (e.clks >= 0) check("done_latency_clks", 128'(clks_since), 128'(e.clks));
        if (e.strobes >= 0) check("timeout_strobes", 128'(strobes_since), 128'(e.strobes));
      end
    end
  end

  task automatic wait_strobe();
    do @(posedge clock); while (!sd_clk_en);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input logic ice, input logic cce, input logic [135:0] card,
                         input int card_len, input logic hold_ack, input logic poke,
                         input logic [47:0] exp_tx, input exp_t e);
    int n, target;
    tx_q.push_back(exp_tx);
    done_q.push_back(e);
    target = done_cnt + 1;
    @(posedge clock); #1;
    resp_ack = 1'b1;
    @(posedge clock); #1;
    resp_ack = hold_ack;
    cmd_index = idx; cmd_argument = arg; resp_type = rt;
    index_check_en = ice; crc_check_en = cce;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (poke) begin
      repeat (40) @(posedge clock);
      #1;
      cmd_index = 6'h05; cmd_argument = ~arg; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    if (card_len > 0) begin
      n = 0;
      while (!cmd_oe && n < 1000) begin @(posedge clock); #1; n++; end
      while (cmd_oe && n < 1000) begin @(posedge clock); #1; n++; end
      if (n >= 1000) bound_fail("tx_end_wait");
      wait_strobe();
      #2;
      for (int i = card_len - 1; i >= 0; i--) begin
        cmd_pin_in = card[i];
        wait_strobe();
        #2;
      end
      cmd_pin_in = 1'b1;
    end
    n = 0;
    while (done_cnt < target && n < 2000) begin @(posedge clock); #1; n++; end
    if (done_cnt < target) bound_fail("cmd_done_wait");
    resp_ack = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [119:0] cid;
    logic [135:0] long_card;
    int n;
    cid = 120'h112233445566778899AABBCCDDEEFF;
    long_card = {8'h3F, cid, crc_model({8'h0, cid}, 120), 1'b1};

    repeat (3) @(posedge clock);
    #1;
    check("rst_cmd_oe", {127'h0, cmd_oe}, 128'h0);
    check("rst_cmd_pin_out", {127'h0, cmd_pin_out}, 128'h1);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_cmd_done", {127'h0, cmd_done}, 128'h0);
    check("rst_resp_valid", {127'h0, resp_valid}, 128'h0);
    check("rst_response", response, 128'h0);
    check("rst_errors", {124'h0, timeout_err, crc_err, index_err, end_bit_err}, 128'h0);
    reset = 1'b0;

    // CMD0, no response: done one clock after the end bit.
    run_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 48'h400000000095,
            mk_exp(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1, -1));

    // CMD8 with a clean R7; a second start mid-frame must be ignored.
    run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, {88'h0, 48'h08000001AA13}, 48, 1'b0, 1'b1,
            48'h48000001AA87, mk_exp(1'b1, 128'h1AA, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1));
    check("resp_valid_held", {127'h0, resp_valid}, 128'h1);
    resp_ack = 1'b1;
    @(posedge clock); #1;
    resp_ack = 1'b0;
    check("resp_valid_acked", {127'h0, resp_valid}, 128'h0);

    // Wrong index returned with a valid CRC.
    run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, {88'h0, frame48(40'h09000001AA)}, 48, 1'b0, 1'b0,
            48'h48000001AA87, mk_exp(1'b1, 128'h1AA, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1));

    // Corrupted CRC byte.
    run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, {88'h0, 48'h08000001AA15}, 48, 1'b0, 1'b0,
            48'h48000001AA87, mk_exp(1'b1, 128'h1AA, 1'b0, EXP_CRC_BAD, 1'b0, 1'b0, -1, -1));

    // Bad end bit, with resp_ack held high across the completing clock.
    run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, {88'h0, 48'h08000001AA12}, 48, 1'b1, 1'b0,
            48'h48000001AA87, mk_exp(1'b1, 128'h1AA, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1));
    check("resp_valid_after_held_ack", {127'h0, resp_valid}, 128'h0);

    // No card response: timeout after 64 strobes.
    run_cmd(6'd55, 32'h0, 2'b10, 1'b1, 1'b1, '0, 0, 1'b0, 1'b0, frame48({2'b01, 6'd55, 32'h0}),
            mk_exp(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 64));

    // CMD2 with a 136-bit R2; the index check must not apply.
    run_cmd(6'd2, 32'h0, 2'b01, 1'b1, 1'b1, long_card, 136, 1'b0, 1'b0,
            frame48({2'b01, 6'd2, 32'h0}),
            mk_exp(1'b1, {8'h00, cid}, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1));

    // Reset at TX bit 20 aborts silently.
    @(posedge clock); #1;
    cmd_index = 6'd8; cmd_argument = 32'h1AA; resp_type = 2'b10; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (tx_bits < 20 && n < 1000) begin @(negedge clock); n++; end
    if (tx_bits < 20) bound_fail("tx_bit20_wait");
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_cmd_oe", {127'h0, cmd_oe}, 128'h0);
    check("abort_busy", {127'h0, busy}, 128'h0);
    check("abort_cmd_done", {127'h0, cmd_done}, 128'h0);
    repeat (20) @(posedge clock);
    #1;

    // Fresh full frame after the abort.
    run_cmd(6'd8, 32'h1AA, 2'b10, 1'b1, 1'b1, {88'h0, 48'h08000001AA13}, 48, 1'b0, 1'b0,
            48'h48000001AA87, mk_exp(1'b1, 128'h1AA, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1));

    check("leftover_expectations", 128'(done_q.size() + tx_q.size()), 128'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
